// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and helpers for the UART instruction-memory
//               loader: loader/RX state encodings and baud divisor function.
//               The CSUM loader state is only used when LOADER_CHECKSUM_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Loader (image-level) states
    typedef enum logic [2:0] {
        LD_HDR_LO = 3'd0,
        LD_HDR_HI = 3'd1,
        LD_DATA   = 3'd2,
        LD_CSUM   = 3'd3,
        LD_DONE   = 3'd4,
        LD_ERR    = 3'd5
    } ld_state_t;

    // UART receiver (bit-level) states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per UART bit (integer division)
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver. Two-flop input synchroniser, baud
//               counter and RX FSM. Emits a one-cycle byte_valid with the
//               byte, or a one-cycle frame_err when the stop bit reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q;
    rx_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    // Synchroniser and state registers; synchroniser idles high like the line
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // RX FSM: start-bit qualification at half bit, then mid-bit sampling
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line already back high is a glitch, not a start bit
                    state_d   = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d        = '0;
                    byte_valid_d = sync2_q;
                    frame_err_d  = !sync2_q;
                    state_d      = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_imem_loader
// Description : Boot-time program loader. Receives a length-prefixed image
//               over UART, writes it word by word into instruction memory and
//               holds the core in reset until the image is loaded.
//               Optional macro LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum byte over header and data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    ld_state_t         state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       words_q, words_d;
    logic [16:0]       n_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Loader state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LD_HDR_LO;
            n_q        <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            words_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Loader FSM: header parse, little-endian word assembly, write strike
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;
        n_full     = {1'b0, byte_data, n_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        if (byte_valid && (state_q == LD_HDR_LO || state_q == LD_HDR_HI ||
                           state_q == LD_DATA)) begin
            csum_d = csum_q ^ byte_data;
        end
`endif

        // Cycle after a strike: advance address/count and detect image end
        if (we_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            words_d = words_q + 16'd1;
            if (words_q + 16'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = LD_CSUM;
`else
                state_d = LD_DONE;
`endif
            end
        end

        case (state_q)
            LD_HDR_LO: begin
                if (frame_err) begin
                    state_d = LD_ERR;
                end else if (byte_valid) begin
                    n_d[7:0] = byte_data;
                    state_d  = LD_HDR_HI;
                end
            end
            LD_HDR_HI: begin
                if (frame_err) begin
                    state_d = LD_ERR;
                end else if (byte_valid) begin
                    n_d = n_full[15:0];
                    if (n_full == 17'd0) begin
                        state_d = LD_DONE;
                    end else if (n_full > CAPACITY) begin
                        state_d = LD_ERR;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (frame_err) begin
                    state_d = LD_ERR;
                end else if (byte_valid) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {byte_data, word_q[23:0]};
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (frame_err) begin
                    state_d = LD_ERR;
                end else if (byte_valid) begin
                    state_d = (byte_data == csum_q) ? LD_DONE : LD_ERR;
                end
            end
`endif
            // DONE and ERR hold until reset; received bytes are discarded
            default: ;
        endcase
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign core_rst     = (state_q != LD_DONE);
    assign load_done    = (state_q == LD_DONE);
    assign load_err     = (state_q == LD_ERR);

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_imem_loader
// Description : Directed self-checking bench for uart_imem_loader at
//               CLK_FREQ=16, BAUD=1 (16 clocks per bit), ADDR_W=4.
//               Extra checksum scenarios run when LOADER_CHECKSUM_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int n_pass  = 0;
    int n_total = 0;

    // Write monitor: records every cycle in which imem_we is high
    int          we_cnt = 0;
    logic [3:0]  wa [0:15];
    logic [31:0] wd [0:15];
    int          base;

    uart_imem_loader #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .ADDR_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Sample write strikes on the falling edge
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa[we_cnt[3:0]] = imem_addr;
            wd[we_cnt[3:0]] = imem_wdata;
            we_cnt = we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One 8N1 frame, 16 clocks per bit; stop_bit selects a good or bad stop
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    {31'd0, imem_we},    32'd0);
        check({tag, "_addr"},  {28'd0, imem_addr},  32'd0);
        check({tag, "_wdata"}, imem_wdata,          32'd0);
        check({tag, "_crst"},  {31'd0, core_rst},   32'd1);
        check({tag, "_done"},  {31'd0, load_done},  32'd0);
        check({tag, "_err"},   {31'd0, load_err},   32'd0);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst0");

        // Short low glitch on an idle line must not start a frame
        base = we_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_err",   {31'd0, load_err},  32'd0);
        check("glitch_done",  {31'd0, load_done}, 32'd0);
        check("glitch_words", {16'd0, words_loaded}, 32'd0);

        // Two-word image: header 02 00
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        check("mid_crst", {31'd0, core_rst}, 32'd1);
        send_byte(8'h93, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h15, 1'b1); send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h97, 1'b1);
`endif
        check("two_wecnt", we_cnt - base, 32'd2);
        check("two_a0", {28'd0, wa[base[3:0]]}, 32'd0);
        check("two_d0", wd[base[3:0]], 32'h00000513);
        check("two_a1", {28'd0, wa[4'(base + 1)]}, 32'd1);
        check("two_d1", wd[4'(base + 1)], 32'h00150593);
        check("two_done",  {31'd0, load_done}, 32'd1);
        check("two_crst",  {31'd0, core_rst},  32'd0);
        check("two_words", {16'd0, words_loaded}, 32'd2);
        check("two_err",   {31'd0, load_err},  32'd0);
        check("two_addr",  {28'd0, imem_addr}, 32'd2);

        // Bytes after DONE are ignored
        send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        check("post_wecnt", we_cnt - base, 32'd2);
        check("post_done",  {31'd0, load_done}, 32'd1);

        // Empty image
        pulse_reset();
        check_reset_values("rst1");
        base = we_cnt;
        send_byte(8'h00, 1'b1);
        check("empty_mid_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h00, 1'b1);
        check("empty_done",  {31'd0, load_done}, 32'd1);
        check("empty_crst",  {31'd0, core_rst},  32'd0);
        check("empty_wecnt", we_cnt - base, 32'd0);

        // Oversized image: N=17 exceeds 16-word capacity
        pulse_reset();
        base = we_cnt;
        send_byte(8'h11, 1'b1); send_byte(8'h00, 1'b1);
        check("big_err",  {31'd0, load_err}, 32'd1);
        check("big_crst", {31'd0, core_rst}, 32'd1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        check("big_wecnt", we_cnt - base, 32'd0);
        check("big_err2",  {31'd0, load_err},  32'd1);
        check("big_done",  {31'd0, load_done}, 32'd0);

        // Exactly-full boundary: N=16 is accepted
        pulse_reset();
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        check("full_err", {31'd0, load_err}, 32'd0);

        // Framing error mid-image, then recovery after reset
        pulse_reset();
        base = we_cnt;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        check("ferr_err",   {31'd0, load_err}, 32'd1);
        check("ferr_crst",  {31'd0, core_rst}, 32'd1);
        check("ferr_wecnt", we_cnt - base, 32'd0);
        pulse_reset();
        check_reset_values("rst2");
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h01, 1'b1);
`endif
        check("rec_wecnt", we_cnt - base, 32'd1);
        check("rec_a0", {28'd0, wa[base[3:0]]}, 32'd0);
        check("rec_d0", wd[base[3:0]], 32'hDDCCBBAA);
        check("rec_done",  {31'd0, load_done}, 32'd1);
        check("rec_words", {16'd0, words_loaded}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum: 01^00^01^02^03^04 = 05
        pulse_reset();
        base = we_cnt;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        check("cs_pre_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h05, 1'b1);
        check("cs_ok_done", {31'd0, load_done}, 32'd1);
        check("cs_ok_d0",   wd[base[3:0]], 32'h04030201);
        check("cs_ok_wecnt", we_cnt - base, 32'd1);
        // Bad checksum
        pulse_reset();
        base = we_cnt;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        check("cs_bad_err",  {31'd0, load_err}, 32'd1);
        check("cs_bad_crst", {31'd0, core_rst}, 32'd1);
        check("cs_bad_d0",   wd[base[3:0]], 32'h04030201);
        check("cs_bad_wecnt", we_cnt - base, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
